// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold buffer, IF/ID register.
// Ports: clk/rst_n (sync, active-low), pc_addr/pc_stall/pc_plus4 to the PC register,
//   flush/id_stall from execute/decode, imem_req/addr/gnt/rvalid/rdata to memory,
//   if_id_valid/pc/instr to decode; perf_fetch_cnt/perf_stall_cnt when IF_PERF_EN is defined.
module if_fetch_unit #(
  parameter int WIDTH_I = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH_I-1:0] pc_addr,
  output logic               pc_stall,
  output logic [WIDTH_I-1:0] pc_plus4,
  input  logic               flush,
  input  logic               id_stall,
  output logic               imem_req,
  output logic [WIDTH_I-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [WIDTH_I-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [WIDTH_I-1:0] if_id_pc,
  output logic [WIDTH_I-1:0] if_id_instr
`ifdef IF_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t             state_q;
  logic [WIDTH_I-1:0] req_pc_q;
  logic               hold_vld_q;
  logic [WIDTH_I-1:0] hold_pc_q;
  logic [WIDTH_I-1:0] hold_instr_q;

  logic               grant;
  logic               id_free;
  logic               wait_load;
  logic               hold_load;
  logic               load;
  logic [WIDTH_I-1:0] load_pc;
  logic [WIDTH_I-1:0] load_instr;

  // A flushing cycle never issues, so the redirect cannot race a grant.
  assign imem_req  = (state_q == REQ) & ~flush;
  assign imem_addr = pc_addr;
  assign grant     = imem_req & imem_gnt;
  assign pc_stall  = ~(grant | flush);
  assign pc_plus4  = pc_addr + WIDTH_I'(4);

  // IF/ID can take new data if empty or being consumed this cycle.
  assign id_free   = ~if_id_valid | ~id_stall;
  assign wait_load = (state_q == WAIT) & imem_rvalid
                   & ~flush & id_free;
  assign hold_load = (state_q == HOLD) & hold_vld_q
                   & ~flush & ~id_stall;
  assign load      = wait_load | hold_load;
  assign load_pc    = hold_load ? hold_pc_q : req_pc_q;
  assign load_instr = hold_load ? hold_instr_q : imem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_pc_q     <= '0;
      hold_vld_q   <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      if_id_valid  <= 1'b0;
      if_id_pc     <= '0;
      if_id_instr  <= '0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (grant) begin
            state_q  <= WAIT;
            req_pc_q <= pc_addr;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (flush || id_free) begin
              state_q <= REQ;
            end else begin
              state_q      <= HOLD;
              hold_vld_q   <= 1'b1;
              hold_pc_q    <= req_pc_q;
              hold_instr_q <= imem_rdata;
            end
          end else if (flush) begin
            state_q <= DROP;
          end
        end
        HOLD: begin
          if (flush || !id_stall) begin
            state_q    <= REQ;
            hold_vld_q <= 1'b0;
          end
        end
        // The in-flight response must still arrive before a new request.
        DROP: begin
          if (imem_rvalid) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase

      if (flush) begin
        if_id_valid <= 1'b0;
      end else if (load) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= load_pc;
        if_id_instr <= load_instr;
      end else if (!id_stall) begin
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state_q != IDLE && pc_stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: pc_plus4 vector table,
// scoreboarded fetch sequences, hold/flush/reset corner cases.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        pc_stall;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.WIDTH_I(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .pc_stall    (pc_stall),
    .pc_plus4    (pc_plus4),
    .flush       (flush),
    .id_stall    (id_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (gnt),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus4;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[6];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  task automatic pop_chk(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, ifid pc %h", nm, if_id_pc);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_valid"}, {31'd0, if_id_valid}, 32'd1);
      chk({nm, "_pc"}, if_id_pc, e.pc);
      chk({nm, "_instr"}, if_id_instr, e.instr);
    end
  endtask

  // Issue one request at pc after nwait refused cycles, answer it
  // one cycle after grant and check the IF/ID load.
  task automatic fetch(input logic [31:0] pc, input int nwait);
    pc_addr = pc;
    gnt = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      #1;
      chk("nogrant_stall", {31'd0, pc_stall}, 32'd1);
      tick();
    end
    gnt = 1'b1;
    #1;
    chk("req_on", {31'd0, imem_req}, 32'd1);
    chk("grant_adv", {31'd0, pc_stall}, 32'd0);
    tick();
    gnt = 1'b0;
    pc_addr = pc + 32'd4;
    rvalid = 1'b1;
    rdata = mem(pc);
    sbq.push_back('{pc, mem(pc)});
    tick();
    rvalid = 1'b0;
    pop_chk("deliver");
    #1;
    chk("next_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    vt[0] = '{32'h0000_0000, 32'h0000_0004};
    vt[1] = '{32'h0000_0004, 32'h0000_0008};
    vt[2] = '{32'h7FFF_FFFC, 32'h8000_0000};
    vt[3] = '{32'hFFFF_FFFC, 32'h0000_0000};
    vt[4] = '{32'hFFFF_FFFE, 32'h0000_0002};
    vt[5] = '{32'h1234_5678, 32'h1234_567C};

    rst_n = 1'b0;
    flush = 1'b0;
    id_stall = 1'b0;
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    pc_addr = '0;
    tick();
    tick();

    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_stall", {31'd0, pc_stall}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      pc_addr = vt[i].pc;
      #1;
      chk("pc_plus4", pc_plus4, vt[i].plus4);
      chk("imem_addr", imem_addr, vt[i].pc);
    end

    // Release: one IDLE cycle, then REQ.
    pc_addr = '0;
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    chk("idle_stall", {31'd0, pc_stall}, 32'd1);
    tick();

    // Zero-wait stream: 2 cycles per instruction.
    fetch(32'h0, 0);
    fetch(32'h4, 0);
    fetch(32'h8, 0);
    tick();
    chk("valid_clear", {31'd0, if_id_valid}, 32'd0);

    // Decode stall while a response arrives: hold buffer.
    fetch(32'h20, 0);
    id_stall = 1'b1;
    pc_addr = 32'h24;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    pc_addr = 32'h28;
    rvalid = 1'b1;
    rdata = 32'h00A0_0093;
    sbq.push_back('{32'h24, 32'h00A0_0093});
    tick();
    rvalid = 1'b0;
    chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
    chk("hold_pc", if_id_pc, 32'h20);
    chk("hold_instr", if_id_instr, mem(32'h20));
    #1;
    chk("hold_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("hold2_pc", if_id_pc, 32'h20);
    id_stall = 1'b0;
    tick();
    pop_chk("hold_out");
    #1;
    chk("hold_next_req", {31'd0, imem_req}, 32'd1);

    // Flush in WAIT, response next cycle is dropped.
    id_stall = 1'b1;
    pc_addr = 32'h10;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    flush = 1'b1;
    pc_addr = 32'h14;
    #1;
    chk("flush_stall", {31'd0, pc_stall}, 32'd0);
    chk("flush_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
    pc_addr = 32'h100;
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    rvalid = 1'b0;
    chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
    #1;
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    id_stall = 1'b0;
    fetch(32'h100, 0);

    // Flush and rvalid in the same WAIT cycle.
    id_stall = 1'b1;
    pc_addr = 32'h104;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    flush = 1'b1;
    rvalid = 1'b1;
    rdata = mem(32'h104);
    tick();
    flush = 1'b0;
    rvalid = 1'b0;
    chk("fr_valid", {31'd0, if_id_valid}, 32'd0);
    #1;
    chk("fr_req", {31'd0, imem_req}, 32'd1);
    id_stall = 1'b0;

    // Reset while WAIT, late response ignored.
    fetch(32'h200, 0);
    pc_addr = 32'h204;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mrst_pc", if_id_pc, 32'd0);
    chk("mrst_instr", if_id_instr, 32'd0);
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_stall", {31'd0, pc_stall}, 32'd1);
    rst_n = 1'b1;
    rvalid = 1'b1;
    rdata = 32'hBAD0_0BAD;
    tick();
    rvalid = 1'b0;
    chk("late_valid", {31'd0, if_id_valid}, 32'd0);
    chk("late_instr", if_id_instr, 32'd0);
    #1;
    chk("late_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("late2_valid", {31'd0, if_id_valid}, 32'd0);

    // Five deliveries with four refused cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch(32'h300, 1);
    fetch(32'h304, 1);
    fetch(32'h308, 1);
    fetch(32'h30C, 1);
    fetch(32'h310, 0);
`ifdef IF_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd5);
    chk("perf_stall", perf_stall_cnt, 32'd9);
`endif

    chk("sb_drained", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
